// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first, one bit per clock, over WIDTH RUN cycles.
// Define SERIAL_SUB_OVERFLOW_EN to register a two's-complement overflow flag; otherwise overflow is tied to 0.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bit_d, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    bit_d  = a_sh_q[0] ^ b_sh_q[0] ^ bin_q;
    bout_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bin_q);

    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    bin_d    = bin_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {bit_d, res_q[WIDTH-1:1]};
        bin_d  = bout_d;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the result together with the done pulse.
          state_d  = DONE;
          done_d   = 1'b1;
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          borrow_d = bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          a_sh_d  = a;
          b_sh_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, overflow;
  logic [W-1:0] diff;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] ref_diff(input int unsigned x, input int unsigned y);
    int unsigned r;
    r = (x - y) % (1 << W);
    return r[W-1:0];
  endfunction

  function automatic logic ref_borrow(input int unsigned x, input int unsigned y);
    return x < y;
  endfunction

  function automatic logic ref_ovf(input int unsigned x, input int unsigned y);
`ifdef SERIAL_SUB_OVERFLOW_EN
    int sx, sy, sd;
    sx = (x >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
    sy = (y >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
    sd = sx - sy;
    return (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
`else
    return 1'b0;
`endif
  endfunction

  // Launches one subtraction at the current negedge and follows it to done.
  // glitch pulses start at RUN cycles 2 and 5; chain_a/chain_b start a back-to-back op in the done cycle.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit glitch,
                       input bit chain, input logic [W-1:0] ca, input logic [W-1:0] cb);
    int cyc;
    int busy_cnt;
    int ops;
    logic [W-1:0] xa, xb;
    xa = av; xb = bv;
    ops = chain ? 2 : 1;
    start = 1'b1; a = av; b = bv;
    for (int k = 0; k < ops; k++) begin
      cyc = 0;
      busy_cnt = 0;
      while (1) begin
        @(negedge clk);
        cyc++;
        if (done || cyc >= 30) break;
        if (busy) busy_cnt++;
        start = glitch && (cyc == 2 || cyc == 5);
        a = W'($urandom);
        b = W'($urandom);
      end
      chk("latency", cyc, 9);
      chk("busy_cycles", busy_cnt, 8);
      chk("diff", diff, ref_diff(xa, xb));
      chk("borrow", borrow, ref_borrow(xa, xb));
      chk("overflow", overflow, ref_ovf(xa, xb));
      if (chain && k == 0) begin
        start = 1'b1; a = ca; b = cb;
        xa = ca; xb = cb;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("idle_not_busy", busy, 1'b0);
    chk("diff_hold", diff, ref_diff(xa, xb));
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, '0);
    chk("rst_borrow", borrow, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst = 1'b0;

    do_op(8'h05, 8'h03, 1'b0, 1'b0, '0, '0);
    do_op(8'h03, 8'h05, 1'b0, 1'b0, '0, '0);
    do_op(8'h80, 8'h01, 1'b0, 1'b0, '0, '0);
    do_op(8'h7F, 8'hFF, 1'b0, 1'b0, '0, '0);
    do_op(8'h12, 8'h34, 1'b1, 1'b0, '0, '0);
    do_op(8'h10, 8'h20, 1'b0, 1'b1, 8'hFF, 8'hFF);

    // Reset in RUN cycle 4 aborts the operation without a done pulse.
    start = 1'b1; a = 8'h55; b = 8'h0F;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_diff", diff, '0);
    chk("abort_borrow", borrow, 1'b0);
    chk("abort_ovf", overflow, 1'b0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    do_op(8'h55, 8'h0F, 1'b0, 1'b0, '0, '0);

    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] ra, rb, qa, qb;
      ra = W'($urandom); rb = W'($urandom);
      qa = W'($urandom); qb = W'($urandom);
      do_op(ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), qa, qb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
